trigger_sequencer: RTL and testbench

Multi-level trigger controller for the wavetrace capture path. Holds per-level mask/value/count configuration, drives the shared mask-and-compare pipeline with the active level's mask and value, and consumes its tagged results. Advances through up to NumLevels trigger levels, asserts a trigger, then counts post-trigger samples before reporting done. Sits between the config register interface and the capture buffer write control.

---
 rtl/wavetrace_trig_pkg.sv | 22 ++
 rtl/trig_level_cfg.sv | 74 +++++++
 rtl/trigger_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavetrace_trig_pkg.sv
// Shared definitions for the wavetrace trigger sequencer: FSM state encoding,
// tag layout and default parameter values.
package wavetrace_trig_pkg;

  localparam int DEF_DATA_BITS  = 32;
  localparam int DEF_NUM_LEVELS = 4;
  localparam int DEF_LEVEL_BITS = 2;
  localparam int DEF_COUNT_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Tags are {epoch, level}: the epoch bit sits just above the level field.
  function automatic int tag_epoch_bit(input int level_bits);
    return level_bits;
  endfunction

endpackage

// File: rtl/trig_level_cfg.sv
// Per-level mask/value/count register file. One write port, one registered
// read port addressed by the active trigger level.
module trig_level_cfg
  import wavetrace_trig_pkg::*;
#(
  parameter int DataBits  = DEF_DATA_BITS,
  parameter int NumLevels = DEF_NUM_LEVELS,
  parameter int LevelBits = DEF_LEVEL_BITS,
  parameter int CountBits = DEF_COUNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [LevelBits-1:0] wr_level,
  input  logic [DataBits-1:0]  wr_mask,
  input  logic [DataBits-1:0]  wr_value,
  input  logic [CountBits-1:0] wr_count,
  input  logic [LevelBits-1:0] rd_level,
  output logic [DataBits-1:0]  rd_mask,
  output logic [DataBits-1:0]  rd_value,
  output logic [CountBits-1:0] rd_count
);

  logic [DataBits-1:0]  mask_arr  [NumLevels];
  logic [DataBits-1:0]  value_arr [NumLevels];
  logic [CountBits-1:0] count_arr [NumLevels];

  genvar gi;
  generate
    for (gi = 0; gi < NumLevels; gi++) begin : g_level
      logic [DataBits-1:0]  mask_reg;
      logic [DataBits-1:0]  value_reg;
      logic [CountBits-1:0] count_reg;

      // Entry gi: written only when addressed; out-of-range levels match no entry.
      always_ff @(posedge clk) begin
        if (rst) begin
          mask_reg  <= '0;
          value_reg <= '0;
          count_reg <= '0;
        end else if (wr_en && (wr_level == LevelBits'(gi))) begin
          mask_reg  <= wr_mask;
          value_reg <= wr_value;
          count_reg <= wr_count;
        end
      end

      assign mask_arr[gi]  = mask_reg;
      assign value_arr[gi] = value_reg;
      assign count_arr[gi] = count_reg;
    end
  endgenerate

  // Registered read of the entry selected by the active level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_mask  <= '0;
      rd_value <= '0;
      rd_count <= '0;
    end else begin
      rd_mask  <= '0;
      rd_value <= '0;
      rd_count <= '0;
      for (int i = 0; i < NumLevels; i++) begin
        if (rd_level == LevelBits'(i)) begin
          rd_mask  <= mask_arr[i];
          rd_value <= value_arr[i];
          rd_count <= count_arr[i];
        end
      end
    end
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-level trigger controller: walks through the configured levels on
// tagged comparator results, pulses trig, counts post-trigger samples, then
// pulses done.
module trigger_sequencer
  import wavetrace_trig_pkg::*;
#(
  parameter int DataBits  = DEF_DATA_BITS,
  parameter int NumLevels = DEF_NUM_LEVELS,
  parameter int LevelBits = DEF_LEVEL_BITS,
  parameter int CountBits = DEF_COUNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_wr,
  input  logic [LevelBits-1:0] cfg_level,
  input  logic [DataBits-1:0]  cfg_mask,
  input  logic [DataBits-1:0]  cfg_value,
  input  logic [CountBits-1:0] cfg_count,
  input  logic [LevelBits-1:0] last_level,
  input  logic [CountBits-1:0] post_count,
  input  logic                 arm,
  input  logic                 abort,
  output logic [DataBits-1:0]  cmp_mask,
  output logic [DataBits-1:0]  cmp_value,
  output logic [LevelBits:0]   cmp_tag,
  input  logic                 res_valid,
  input  logic                 res_match,
  input  logic [LevelBits:0]   res_tag,
  output logic                 armed,
  output logic [LevelBits-1:0] cur_level,
  output logic                 trig,
  output logic                 done,
  output logic                 busy
);

  localparam int                   TagEpochBit = tag_epoch_bit(LevelBits);
  localparam logic [LevelBits-1:0] MaxLevel    = LevelBits'(NumLevels - 1);

  state_t               state_reg;
  logic                 epoch_reg;
  logic [LevelBits-1:0] cur_level_reg;
  logic [LevelBits-1:0] last_level_reg;
  logic [CountBits-1:0] match_cnt_reg;
  logic [CountBits-1:0] post_cnt_reg;
  logic [CountBits-1:0] post_target_reg;
  logic [LevelBits:0]   cmp_tag_reg;
  logic                 trig_reg;
  logic                 done_reg;
  logic                 armed_reg;
  logic                 busy_reg;

  logic                 cfg_we;
  logic [CountBits-1:0] cfg_rd_count;
  logic [CountBits-1:0] req_count;
  logic [CountBits-1:0] match_inc;
  logic [CountBits-1:0] post_inc;
  logic [LevelBits-1:0] last_level_clamped;
  logic                 qualify;

  // Configuration is frozen while a run is in progress.
  assign cfg_we = cfg_wr && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  trig_level_cfg #(
    .DataBits  (DataBits),
    .NumLevels (NumLevels),
    .LevelBits (LevelBits),
    .CountBits (CountBits)
  ) u_cfg (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cfg_we),
    .wr_level (cfg_level),
    .wr_mask  (cfg_mask),
    .wr_value (cfg_value),
    .wr_count (cfg_count),
    .rd_level (cur_level_reg),
    .rd_mask  (cmp_mask),
    .rd_value (cmp_value),
    .rd_count (cfg_rd_count)
  );

  // A level count of zero behaves as one; counters saturate instead of wrapping.
  assign req_count          = (cfg_rd_count == '0) ? CountBits'(1) : cfg_rd_count;
  assign match_inc          = (match_cnt_reg == '1) ? match_cnt_reg : match_cnt_reg + 1'b1;
  assign post_inc           = (post_cnt_reg == '1) ? post_cnt_reg : post_cnt_reg + 1'b1;
  assign last_level_clamped = (last_level > MaxLevel) ? MaxLevel : last_level;

  // Only results compared against this run's active level may count as matches.
  assign qualify = res_valid && res_match &&
                   (res_tag[TagEpochBit] == epoch_reg) &&
                   (res_tag[LevelBits-1:0] == cur_level_reg);

  // Tag issued with each sample tracks the level/epoch the comparator is set up for.
  always_ff @(posedge clk) begin
    if (rst) cmp_tag_reg <= '0;
    else     cmp_tag_reg <= {epoch_reg, cur_level_reg};
  end

  // Main trigger FSM with registered status and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      epoch_reg       <= 1'b0;
      cur_level_reg   <= '0;
      last_level_reg  <= '0;
      match_cnt_reg   <= '0;
      post_cnt_reg    <= '0;
      post_target_reg <= '0;
      trig_reg        <= 1'b0;
      done_reg        <= 1'b0;
      armed_reg       <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      trig_reg <= 1'b0;
      done_reg <= 1'b0;
      if (abort) begin
        state_reg     <= ST_IDLE;
        match_cnt_reg <= '0;
        post_cnt_reg  <= '0;
        armed_reg     <= 1'b0;
        busy_reg      <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              last_level_reg  <= last_level_clamped;
              post_target_reg <= post_count;
              epoch_reg       <= ~epoch_reg;
              cur_level_reg   <= '0;
              match_cnt_reg   <= '0;
              post_cnt_reg    <= '0;
              state_reg       <= ST_ARMED;
              armed_reg       <= 1'b1;
              busy_reg        <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (qualify) begin
              if (match_inc >= req_count) begin
                match_cnt_reg <= '0;
                if (cur_level_reg == last_level_reg) begin
                  trig_reg  <= 1'b1;
                  armed_reg <= 1'b0;
                  if (post_target_reg == '0) begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_DONE;
                  end else begin
                    state_reg <= ST_POST;
                  end
                end else begin
                  cur_level_reg <= cur_level_reg + 1'b1;
                end
              end else begin
                match_cnt_reg <= match_inc;
              end
            end
          end
          ST_POST: begin
            if (res_valid) begin
              post_cnt_reg <= post_inc;
              if (post_inc >= post_target_reg) begin
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= ST_DONE;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmp_tag   = cmp_tag_reg;
  assign cur_level = cur_level_reg;
  assign trig      = trig_reg;
  assign done      = done_reg;
  assign armed     = armed_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer. The bench plays the comparator role
// (zero-latency mask-and-compare on the DUT's cmp_* outputs) and keeps a
// scoreboard of expected trig/done per result beat.
module tb_trigger_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [1:0]  cfg_level;
  logic [31:0] cfg_mask;
  logic [31:0] cfg_value;
  logic [15:0] cfg_count;
  logic [1:0]  last_level;
  logic [15:0] post_count;
  logic        arm;
  logic        abort;
  logic [31:0] cmp_mask;
  logic [31:0] cmp_value;
  logic [2:0]  cmp_tag;
  logic        res_valid;
  logic        res_match;
  logic [2:0]  res_tag;
  logic        armed;
  logic [1:0]  cur_level;
  logic        trig;
  logic        done;
  logic        busy;

  trigger_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .cfg_level  (cfg_level),
    .cfg_mask   (cfg_mask),
    .cfg_value  (cfg_value),
    .cfg_count  (cfg_count),
    .last_level (last_level),
    .post_count (post_count),
    .arm        (arm),
    .abort      (abort),
    .cmp_mask   (cmp_mask),
    .cmp_value  (cmp_value),
    .cmp_tag    (cmp_tag),
    .res_valid  (res_valid),
    .res_match  (res_match),
    .res_tag    (res_tag),
    .armed      (armed),
    .cur_level  (cur_level),
    .trig       (trig),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  trig;
    logic  done;
    string name;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic epoch_m    = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT pulses.
  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = q.pop_front();
      chk({e.name, ".trig"}, {31'd0, trig}, {31'd0, e.trig});
      chk({e.name, ".done"}, {31'd0, done}, {31'd0, done === 1'bx ? 1'b0 : e.done});
      $display("beat %s: trig=%0b done=%0b cur_level=%0d", e.name, trig, done, cur_level);
    end
  endtask

  task automatic push(input logic et, input logic ed, input string name);
    exp_t e;
    e.trig = et;
    e.done = ed;
    e.name = name;
    q.push_back(e);
  endtask

  // Sample beat: comparator result from the current cmp outputs.
  task automatic beat(input logic [31:0] sample, input logic et, input logic ed, input string name);
    @(negedge clk);
    res_valid = 1'b1;
    res_match = ((sample & cmp_mask) == (cmp_value & cmp_mask));
    res_tag   = cmp_tag;
    push(et, ed, name);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    res_match = 1'b0;
    check_out();
  endtask

  // Beat with an explicit match flag and tag (stale / in-flight results).
  task automatic raw(input logic m, input logic [2:0] tag, input logic et, input logic ed, input string name);
    @(negedge clk);
    res_valid = 1'b1;
    res_match = m;
    res_tag   = tag;
    push(et, ed, name);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    res_match = 1'b0;
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      res_valid = 1'b0;
      push(1'b0, 1'b0, "idle");
      @(posedge clk);
      #1;
      check_out();
    end
  endtask

  task automatic cfg_write(input logic [1:0] lvl, input logic [31:0] m, input logic [31:0] v, input logic [15:0] c);
    @(negedge clk);
    cfg_wr    = 1'b1;
    cfg_level = lvl;
    cfg_mask  = m;
    cfg_value = v;
    cfg_count = c;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
    $display("cfg_write level=%0d mask=%0h value=%0h count=%0d", lvl, m, v, c);
  endtask

  task automatic do_arm(input logic [1:0] ll, input logic [15:0] pc, input string name);
    @(negedge clk);
    arm        = 1'b1;
    last_level = ll;
    post_count = pc;
    @(posedge clk);
    #1;
    arm     = 1'b0;
    epoch_m = ~epoch_m;
    chk({name, ".armed"}, {31'd0, armed}, 32'd1);
    chk({name, ".busy"}, {31'd0, busy}, 32'd1);
    chk({name, ".cur_level"}, {30'd0, cur_level}, 32'd0);
    $display("arm %s: last_level=%0d post_count=%0d", name, ll, pc);
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_level = '0; cfg_mask = '0; cfg_value = '0; cfg_count = '0;
    last_level = '0; post_count = '0; arm = 1'b0; abort = 1'b0;
    res_valid = 1'b0; res_match = 1'b0; res_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.armed", {31'd0, armed}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.trig", {31'd0, trig}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.cur_level", {30'd0, cur_level}, 32'd0);
    chk("rst.cmp_mask", cmp_mask, 32'd0);
    chk("rst.cmp_value", cmp_value, 32'd0);
    chk("rst.cmp_tag", {29'd0, cmp_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single level, post_count 3.
    cfg_write(2'd0, 32'hFF, 32'h12, 16'd1);
    do_arm(2'd0, 16'd3, "t1");
    idle(1);
    chk("t1.cmp_mask", cmp_mask, 32'hFF);
    chk("t1.cmp_value", cmp_value, 32'h12);
    chk("t1.cmp_tag", {29'd0, cmp_tag}, {29'd0, epoch_m, 2'd0});
    beat(32'h34, 1'b0, 1'b0, "t1.0x34");
    beat(32'h12, 1'b1, 1'b0, "t1.0x12");
    chk("t1.post_busy", {31'd0, busy}, 32'd1);
    chk("t1.post_armed", {31'd0, armed}, 32'd0);
    beat(32'h55, 1'b0, 1'b0, "t1.0x55");
    beat(32'h66, 1'b0, 1'b0, "t1.0x66");
    beat(32'h77, 1'b0, 1'b1, "t1.0x77");
    idle(1);
    chk("t1.done_busy", {31'd0, busy}, 32'd0);

    // Two levels: L0 needs two A's, L1 one B.
    cfg_write(2'd0, 32'hF, 32'hA, 16'd2);
    cfg_write(2'd1, 32'hF, 32'hB, 16'd1);
    do_arm(2'd1, 16'd1, "t2");
    idle(1);
    beat(32'hA, 1'b0, 1'b0, "t2.A1"); idle(1);
    beat(32'hB, 1'b0, 1'b0, "t2.B1"); idle(1);
    chk("t2.level_after_B1", {30'd0, cur_level}, 32'd0);
    beat(32'hA, 1'b0, 1'b0, "t2.A2");
    chk("t2.level_after_A2", {30'd0, cur_level}, 32'd1);
    idle(1);
    chk("t2.cmp_value_L1", cmp_value, 32'hB);
    beat(32'hB, 1'b1, 1'b0, "t2.B2"); idle(1);
    beat(32'h0, 1'b0, 1'b1, "t2.post");

    // In-flight results still tagged with level 0 after the advance.
    cfg_write(2'd0, 32'hF, 32'h5, 16'd1);
    cfg_write(2'd1, 32'hF, 32'h9, 16'd1);
    do_arm(2'd1, 16'd2, "t3");
    idle(1);
    beat(32'h5, 1'b0, 1'b0, "t3.L0");
    raw(1'b1, {epoch_m, 2'd0}, 1'b0, 1'b0, "t3.stale0");
    raw(1'b1, {epoch_m, 2'd0}, 1'b0, 1'b0, "t3.stale1");
    raw(1'b1, {epoch_m, 2'd0}, 1'b0, 1'b0, "t3.stale2");
    raw(1'b1, {~epoch_m, 2'd1}, 1'b0, 1'b0, "t3.old_epoch");
    beat(32'h9, 1'b1, 1'b0, "t3.L1");
    beat(32'h1, 1'b0, 1'b0, "t3.post1");
    beat(32'h2, 1'b0, 1'b1, "t3.post2");

    // Abort in POST, reconfigure and re-arm.
    do_arm(2'd0, 16'd5, "t5");
    idle(1);
    beat(32'h5, 1'b1, 1'b0, "t5.trig");
    beat(32'h3, 1'b0, 1'b0, "t5.post1");
    @(negedge clk);
    abort = 1'b1;
    res_valid = 1'b1;
    res_match = 1'b1;
    res_tag = cmp_tag;
    push(1'b0, 1'b0, "t5.abort");
    @(posedge clk);
    #1;
    abort = 1'b0;
    res_valid = 1'b0;
    check_out();
    chk("t5.abort_busy", {31'd0, busy}, 32'd0);
    idle(5);
    cfg_write(2'd0, 32'hF, 32'h7, 16'd1);
    do_arm(2'd0, 16'd1, "t5b");
    idle(1);
    chk("t5b.cmp_value", cmp_value, 32'h7);
    chk("t5b.cmp_tag", {29'd0, cmp_tag}, {29'd0, epoch_m, 2'd0});
    raw(1'b1, {~epoch_m, 2'd0}, 1'b0, 1'b0, "t5b.prev_run");
    beat(32'h7, 1'b1, 1'b0, "t5b.trig");
    beat(32'h0, 1'b0, 1'b1, "t5b.done");

    // post_count 0: trig and done together.
    do_arm(2'd0, 16'd0, "t4");
    idle(1);
    beat(32'h7, 1'b1, 1'b1, "t4.trig_done");
    chk("t4.busy", {31'd0, busy}, 32'd0);
    chk("t4.armed", {31'd0, armed}, 32'd0);

    // cfg_wr during ARMED is ignored; rst mid-POST clears everything.
    do_arm(2'd0, 16'd4, "t6");
    cfg_write(2'd0, 32'hFF, 32'h99, 16'd3);
    idle(1);
    chk("t6.cmp_value_kept", cmp_value, 32'h7);
    chk("t6.cmp_mask_kept", cmp_mask, 32'hF);
    beat(32'h7, 1'b1, 1'b0, "t6.trig");
    beat(32'h1, 1'b0, 1'b0, "t6.post1");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6.rst_busy", {31'd0, busy}, 32'd0);
    chk("t6.rst_armed", {31'd0, armed}, 32'd0);
    chk("t6.rst_cur_level", {30'd0, cur_level}, 32'd0);
    chk("t6.rst_cmp_mask", cmp_mask, 32'd0);
    chk("t6.rst_cmp_value", cmp_value, 32'd0);
    chk("t6.rst_cmp_tag", {29'd0, cmp_tag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    epoch_m = 1'b0;
    idle(2);
    chk("t6.cfg_cleared_mask", cmp_mask, 32'd0);
    chk("t6.cfg_cleared_value", cmp_value, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
